frame_sequencer: RTL and testbench

Sequences acquisitions on the panel timing generator. It issues frame_start and frame_reset to the timing generator and monitors frame_busy and frame_complete. It runs single, burst (N frames) or continuous capture, inserts a programmable inter-frame gap, and guards each frame with a watchdog. It sits between the host register block and timing_generator.

---
 rtl/frame_sequencer.sv | 163 ++++++++++++++++
 tb/tb_frame_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// frame_sequencer: runs single, burst or continuous frame capture on the timing generator, with inter-frame gap, watchdog and abort handling
module frame_sequencer #(
  parameter int BUSY_WAIT_MAX = 16,
  parameter int ABORT_CYCLES  = 4,
  parameter int GAP_W         = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_cmd,
  input  logic             stop_cmd,
  input  logic             abort_cmd,
  input  logic [1:0]       mode,
  input  logic [15:0]      frame_count,
  input  logic [GAP_W-1:0] gap_cycles,
  input  logic [31:0]      timeout_cycles,
  input  logic             tg_frame_busy,
  input  logic             tg_frame_complete,
  output logic             tg_frame_start,
  output logic             tg_frame_reset,
  output logic             seq_busy,
  output logic             seq_done,
  output logic [15:0]      frames_done,
  output logic             timeout_err,
  output logic [2:0]       seq_state
);
  localparam int AW = $clog2(ABORT_CYCLES) + 1;
  localparam logic [AW-1:0] ABORT_LAST = AW'(ABORT_CYCLES - 1);
  localparam logic [31:0] BUSY_LAST = 32'(BUSY_WAIT_MAX - 1);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    ACQUIRE   = 3'd3,
    GAP       = 3'd4,
    ABORT     = 3'd5,
    DONE      = 3'd6
  } state_t;
  state_t           state;
  logic [1:0]       cfg_mode;
  logic [15:0]      cfg_count;
  logic [GAP_W-1:0] cfg_gap;
  logic [31:0]      cfg_timeout;
  logic             stop_pending;
  logic [31:0]      wd;
  logic [GAP_W-1:0] gap_cnt;
  logic [AW-1:0]    abort_cnt;
  logic [15:0]      fd_inc;
  logic [31:0]      wd_inc;
  logic             stopping;
  logic             last_frame;
  logic             acq_timeout;
  logic             gap_last;
  logic             abortable;
  always_comb begin
    fd_inc      = &frames_done ? frames_done : frames_done + 16'd1;
    wd_inc      = &wd ? wd : wd + 32'd1;
    stopping    = stop_pending | stop_cmd;
    last_frame  = stopping | (cfg_mode[1] == cfg_mode[0]) | (cfg_mode == 2'd1 && fd_inc == cfg_count);
    acq_timeout = (|cfg_timeout) && wd == cfg_timeout - 32'd1;
    gap_last    = gap_cnt == cfg_gap - GAP_W'(1);
    abortable   = abort_cmd && (state inside {LAUNCH, WAIT_BUSY, ACQUIRE, GAP});
  end
  assign seq_busy  = state != IDLE;
  assign seq_state = state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cfg_mode       <= '0;
      cfg_count      <= '0;
      cfg_gap        <= '0;
      cfg_timeout    <= '0;
      stop_pending   <= 1'b0;
      wd             <= '0;
      gap_cnt        <= '0;
      abort_cnt      <= '0;
      frames_done    <= '0;
      timeout_err    <= 1'b0;
      tg_frame_start <= 1'b0;
      tg_frame_reset <= 1'b0;
      seq_done       <= 1'b0;
    end else begin
      tg_frame_start <= 1'b0;
      seq_done       <= 1'b0;
      if (abortable) begin
        if (state == ACQUIRE && tg_frame_complete) frames_done <= fd_inc;
        state          <= ABORT;
        tg_frame_reset <= 1'b1;
        abort_cnt      <= '0;
      end else begin
        case (state)
          IDLE: if (start_cmd) begin
            cfg_mode       <= mode;
            cfg_count      <= frame_count == 16'd0 ? 16'd1 : frame_count;
            cfg_gap        <= gap_cycles;
            cfg_timeout    <= timeout_cycles;
            frames_done    <= '0;
            timeout_err    <= 1'b0;
            stop_pending   <= 1'b0;
            state          <= LAUNCH;
            tg_frame_start <= 1'b1;
          end
          LAUNCH: begin
            if (stop_cmd) stop_pending <= 1'b1;
            wd    <= '0;
            state <= WAIT_BUSY;
          end
          WAIT_BUSY: begin
            if (stop_cmd) stop_pending <= 1'b1;
            if (tg_frame_busy) begin
              wd    <= '0;
              state <= ACQUIRE;
            end else if (wd == BUSY_LAST) begin
              timeout_err    <= 1'b1;
              state          <= ABORT;
              tg_frame_reset <= 1'b1;
              abort_cnt      <= '0;
            end else wd <= wd_inc;
          end
          ACQUIRE: begin
            if (stop_cmd) stop_pending <= 1'b1;
            if (tg_frame_complete) begin
              frames_done <= fd_inc;
              wd          <= '0;
              if (last_frame) begin
                state    <= DONE;
                seq_done <= 1'b1;
              end else if (cfg_gap == '0) begin
                state          <= LAUNCH;
                tg_frame_start <= 1'b1;
              end else begin
                state   <= GAP;
                gap_cnt <= '0;
              end
            end else if (acq_timeout) begin
              timeout_err    <= 1'b1;
              state          <= ABORT;
              tg_frame_reset <= 1'b1;
              abort_cnt      <= '0;
            end else wd <= wd_inc;
          end
          GAP: begin
            if (stopping) begin
              state    <= DONE;
              seq_done <= 1'b1;
            end else if (gap_last) begin
              state          <= LAUNCH;
              tg_frame_start <= 1'b1;
            end else gap_cnt <= gap_cnt + GAP_W'(1);
          end
          ABORT: begin
            if (abort_cnt == ABORT_LAST && !tg_frame_busy) begin
              state          <= DONE;
              tg_frame_reset <= 1'b0;
              seq_done       <= 1'b1;
            end else if (abort_cnt != ABORT_LAST) abort_cnt <= abort_cnt + AW'(1);
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: vector table plus directed corner sequences against a timing-generator model
module tb_frame_sequencer;
  localparam int GAP_W = 24;
  logic             clk = 1'b0;
  logic             rst;
  logic             start_cmd, stop_cmd, abort_cmd;
  logic [1:0]       mode;
  logic [15:0]      frame_count;
  logic [GAP_W-1:0] gap_cycles;
  logic [31:0]      timeout_cycles;
  logic             tg_frame_busy, tg_frame_complete;
  logic             tg_frame_start, tg_frame_reset, seq_busy, seq_done, timeout_err;
  logic [15:0]      frames_done;
  logic [2:0]       seq_state;
  frame_sequencer #(.BUSY_WAIT_MAX(16), .ABORT_CYCLES(4), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst), .start_cmd(start_cmd), .stop_cmd(stop_cmd), .abort_cmd(abort_cmd),
    .mode(mode), .frame_count(frame_count), .gap_cycles(gap_cycles), .timeout_cycles(timeout_cycles),
    .tg_frame_busy(tg_frame_busy), .tg_frame_complete(tg_frame_complete),
    .tg_frame_start(tg_frame_start), .tg_frame_reset(tg_frame_reset), .seq_busy(seq_busy),
    .seq_done(seq_done), .frames_done(frames_done), .timeout_err(timeout_err), .seq_state(seq_state)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, n_start, n_done, n_rst, last_start, last_done, rst_rise;
  int starts_q[$], cpl_q[$];
  int t = -1, rcnt = 0, m_lat = 2, m_cpl = 20, m_drop = 2;
  typedef struct {
    logic [1:0] mode;
    int fc, gap, tmo, lat, cpl, stop_after, frames, starts, err;
  } vec_t;
  vec_t vecs[9];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic model_tick();
    tg_frame_complete = 1'b0;
    if (rst) begin
      t = -1; rcnt = 0; tg_frame_busy = 1'b0;
    end else if (tg_frame_reset) begin
      t = -1; rcnt++;
      if (rcnt > m_drop) tg_frame_busy = 1'b0;
    end else begin
      rcnt = 0;
      if (tg_frame_start) t = 0; else if (t >= 0) t++;
      if (t >= 0 && t == m_lat) tg_frame_busy = 1'b1;
      if (t >= 0 && t == m_cpl) begin
        tg_frame_complete = 1'b1; tg_frame_busy = 1'b0; t = -1; cpl_q.push_back(cyc);
      end
    end
  endtask
  task automatic step();
    @(posedge clk); #1;
    start_cmd = 1'b0; stop_cmd = 1'b0; abort_cmd = 1'b0;
    cyc++;
    if (tg_frame_start) begin n_start++; last_start = cyc; starts_q.push_back(cyc); end
    if (seq_done) begin n_done++; last_done = cyc; end
    if (tg_frame_reset) begin n_rst++; if (rst_rise < 0) rst_rise = cyc; end
    model_tick();
  endtask
  task automatic clr();
    n_start = 0; n_done = 0; n_rst = 0; rst_rise = -1; last_start = 0; last_done = 0;
    starts_q.delete(); cpl_q.delete();
  endtask
  task automatic cfg(input logic [1:0] md, input int fc, input int gap, input int tmo, input int lat, input int cpl, input int drop);
    mode = md; frame_count = 16'(fc); gap_cycles = GAP_W'(gap); timeout_cycles = 32'(tmo);
    m_lat = lat; m_cpl = cpl; m_drop = drop;
  endtask
  task automatic do_start();
    clr();
    start_cmd = 1'b1;
    step();
  endtask
  task automatic wait_done(input string nm, input int budget);
    for (int n = 0; n < budget && !seq_done; n++) step();
    chk({nm, " seq_done"}, 32'(seq_done), 1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
  initial begin
    vecs[0] = '{2'd0, 5, 0, 0, 2, 20, -1, 1, 1, 0};
    vecs[1] = '{2'd1, 3, 10, 0, 2, 20, -1, 3, 3, 0};
    vecs[2] = '{2'd1, 0, 0, 0, 2, 20, -1, 1, 1, 0};
    vecs[3] = '{2'd3, 4, 2, 0, 2, 20, -1, 1, 1, 0};
    vecs[4] = '{2'd2, 0, 5, 0, 2, 20, 2, 2, 2, 0};
    vecs[5] = '{2'd0, 1, 0, 18, 2, 20, -1, 1, 1, 0};
    vecs[6] = '{2'd0, 1, 0, 17, 2, 20, -1, 0, 1, 1};
    vecs[7] = '{2'd1, 3, 0, 0, -1, -1, -1, 0, 1, 1};
    vecs[8] = '{2'd1, 2, 0, 3, 1, 3, -1, 2, 2, 0};
    rst = 1'b1; start_cmd = 0; stop_cmd = 0; abort_cmd = 0;
    tg_frame_busy = 0; tg_frame_complete = 0;
    cfg(2'd0, 0, 0, 0, 2, 20, 2);
    clr();
    repeat (3) step();
    chk("rst tg_frame_start", 32'(tg_frame_start), 0);
    chk("rst tg_frame_reset", 32'(tg_frame_reset), 0);
    chk("rst seq_busy", 32'(seq_busy), 0);
    chk("rst seq_done", 32'(seq_done), 0);
    chk("rst frames_done", 32'(frames_done), 0);
    chk("rst timeout_err", 32'(timeout_err), 0);
    chk("rst seq_state", 32'(seq_state), 0);
    rst = 1'b0;
    step();
    foreach (vecs[i]) begin
      cfg(vecs[i].mode, vecs[i].fc, vecs[i].gap, vecs[i].tmo, vecs[i].lat, vecs[i].cpl, 2);
      do_start();
      for (int n = 0; n < 3000 && !seq_done; n++) begin
        if (vecs[i].stop_after == n_start && cyc == last_start + 5) stop_cmd = 1'b1;
        step();
      end
      chk($sformatf("v%0d seq_done", i), 32'(seq_done), 1);
      chk($sformatf("v%0d frames_done", i), 32'(frames_done), 32'(vecs[i].frames));
      chk($sformatf("v%0d starts", i), 32'(n_start), 32'(vecs[i].starts));
      chk($sformatf("v%0d timeout_err", i), 32'(timeout_err), 32'(vecs[i].err));
      step();
      chk($sformatf("v%0d idle", i), 32'(seq_state), 0);
      repeat (2) step();
    end
    cfg(2'd0, 1, 0, 0, 2, 50, 2);
    do_start();
    wait_done("single50", 200);
    chk("single50 starts", 32'(n_start), 1);
    chk("single50 frames_done", 32'(frames_done), 1);
    chk("single50 done after complete", 32'(last_done - (cpl_q.size() > 0 ? cpl_q[0] : 0)), 1);
    chk("single50 timeout_err", 32'(timeout_err), 0);
    repeat (3) step();
    cfg(2'd1, 3, 10, 0, 2, 20, 2);
    do_start();
    wait_done("burst3", 500);
    repeat (5) step();
    chk("burst3 starts", 32'(starts_q.size()), 3);
    chk("burst3 completes", 32'(cpl_q.size()), 3);
    if (starts_q.size() == 3 && cpl_q.size() == 3) begin
      chk("burst3 spacing1", 32'(starts_q[1] - cpl_q[0]), 11);
      chk("burst3 spacing2", 32'(starts_q[2] - cpl_q[1]), 11);
    end
    chk("burst3 frames_done", 32'(frames_done), 3);
    chk("burst3 done count", 32'(n_done), 1);
    cfg(2'd2, 0, 10, 0, 2, 10, 2);
    do_start();
    for (int n = 0; n < 200 && cpl_q.size() == 0; n++) step();
    chk("gapstop complete seen", 32'(cpl_q.size()), 1);
    repeat (2) step();
    stop_cmd = 1'b1;
    step();
    chk("gapstop seq_done", 32'(seq_done), 1);
    chk("gapstop state", 32'(seq_state), 6);
    repeat (15) step();
    chk("gapstop starts", 32'(n_start), 1);
    chk("gapstop frames_done", 32'(frames_done), 1);
    cfg(2'd0, 1, 0, 0, -1, -1, 2);
    do_start();
    wait_done("nobusy", 100);
    chk("nobusy abort entry", 32'(rst_rise - last_start), 17);
    chk("nobusy reset cycles", 32'(n_rst), 4);
    chk("nobusy timeout_err", 32'(timeout_err), 1);
    repeat (2) step();
    cfg(2'd0, 1, 0, 0, 2, 10, 2);
    do_start();
    chk("restart tg_frame_start", 32'(tg_frame_start), 1);
    chk("restart timeout_err cleared", 32'(timeout_err), 0);
    wait_done("restart", 100);
    repeat (2) step();
    cfg(2'd0, 1, 0, 100, 2, -1, 7);
    do_start();
    wait_done("tmo100", 400);
    chk("tmo100 abort entry", 32'(rst_rise - last_start), 103);
    chk("tmo100 reset cycles", 32'(n_rst), 8);
    chk("tmo100 timeout_err", 32'(timeout_err), 1);
    repeat (2) step();
    cfg(2'd2, 0, 0, 0, 2, 20, 2);
    do_start();
    repeat (20) step();
    abort_cmd = 1'b1;
    step();
    chk("abortcpl state", 32'(seq_state), 5);
    chk("abortcpl frames_done", 32'(frames_done), 1);
    chk("abortcpl tg_frame_reset", 32'(tg_frame_reset), 1);
    wait_done("abortcpl", 100);
    chk("abortcpl starts", 32'(n_start), 1);
    repeat (2) step();
    cfg(2'd2, 0, 0, 0, 2, 10, 2);
    do_start();
    for (int n = 0; n < 200 && n_start < 2; n++) step();
    repeat (5) step();
    chk("midrst acquire", 32'(seq_state), 3);
    chk("midrst frames before", 32'(frames_done), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst state", 32'(seq_state), 0);
    chk("midrst seq_busy", 32'(seq_busy), 0);
    chk("midrst frames_done", 32'(frames_done), 0);
    chk("midrst tg_frame_start", 32'(tg_frame_start), 0);
    chk("midrst tg_frame_reset", 32'(tg_frame_reset), 0);
    repeat (5) step();
    chk("midrst stays idle", 32'(seq_state), 0);
    cfg(2'd1, 2, 3, 0, 2, 10, 2);
    do_start();
    repeat (6) step();
    mode = 2'd2; frame_count = 16'd9;
    start_cmd = 1'b1;
    step();
    wait_done("restartignored", 300);
    repeat (20) step();
    chk("restartignored starts", 32'(n_start), 2);
    chk("restartignored frames_done", 32'(frames_done), 2);
    abort_cmd = 1'b1;
    step();
    step();
    chk("idleabort state", 32'(seq_state), 0);
    chk("idleabort tg_frame_reset", 32'(tg_frame_reset), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
